// File: rtl/register_arbiter.sv
// rtl/register_arbiter.sv - arbitrates core writeback and debug access to the register file
// Optional starvation counter enabled by REGISTER_ARBITER_STARVE_EN.
module register_arbiter #(
  parameter int size         = 32,
  parameter int starve_limit = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_write,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_xd,
  output logic        core_stall,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic        dbg_write,
  input  logic [4:0]  dbg_index,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        rf_enable,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_xd,
  output logic        rf_read_sel,
  output logic [4:0]  rf_rs,
  input  logic [31:0] rf_xs
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t state;
  logic   rd_zero;
  logic   in_idle;
  logic   forced;
  logic   grant;
  logic   dbg_wr;
  logic   dbg_rd;
  logic   core_wr;

`ifdef REGISTER_ARBITER_STARVE_EN
  logic [3:0] starve_cnt;

  assign forced = ({28'd0, starve_cnt} >= 32'(starve_limit));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (grant) begin
      starve_cnt <= 4'd0;
    end else if (in_idle && dbg_valid && core_write && !forced) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  // Strict core priority; the limit only matters when the counter is built.
  assign forced = (starve_limit < 0);
`endif

  assign in_idle = (state == IDLE) && !reset;
  assign grant   = in_idle && dbg_valid && (!core_write || forced);
  assign dbg_wr  = grant && dbg_write;
  assign dbg_rd  = grant && !dbg_write;
  assign core_wr = in_idle && core_write && !grant;

  always_comb begin
    rf_rd     = dbg_wr ? dbg_index : core_rd;
    rf_xd     = dbg_wr ? dbg_wdata : core_xd;
    rf_enable = (dbg_wr || core_wr) && (rf_rd != 5'd0) && ({27'd0, rf_rd} < 32'(size));
  end

  assign dbg_ready   = grant;
  assign core_stall  = !reset && ((state == READ) || (state == RESP) || (in_idle && core_write && grant));
  assign rf_read_sel = (state == READ);
  assign dbg_rvalid  = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rf_rs     <= 5'd0;
      rd_zero   <= 1'b0;
      dbg_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dbg_rd) begin
            state   <= READ;
            rf_rs   <= dbg_index;
            // x0 and out-of-range indices read back as zero regardless of rf_xs
            rd_zero <= (dbg_index == 5'd0) || ({27'd0, dbg_index} >= 32'(size));
          end
        end
        READ: begin
          dbg_rdata <= rd_zero ? 32'd0 : rf_xs;
          state     <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
